switch_arbiter_6port: RTL and testbench

Per-output-port switch arbiter for the virtual channel router. Generates the one-hot 6-bit select that drives the output port's 6-line bus mux, and pops the granted input buffer. Grants are round-robin and wormhole-locked: once a head flit wins, the port stays with that input until the tail flit is transferred. All-zero select is issued whenever no flit moves, so the mux emits the idle word 32'h6000_0000.

---
 rtl/router_pkg.sv | 46 ++++
 rtl/rr_pick6.sv | 30 +++
 rtl/switch_arbiter_6port.sv | 169 ++++++++++++++++
 tb/tb_switch_arbiter_6port.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router types, flit-type codes and small helpers
package router_pkg;

  localparam int NPORT = 6;

  // Word the output bus mux drives when the select is all zero.
  localparam logic [31:0] IDLE_WORD = 32'h6000_0000;

  // Flit type codes (bits [31:29] of a flit).
  localparam logic [2:0] FT_HEAD     = 3'b001;
  localparam logic [2:0] FT_BODY     = 3'b010;
  localparam logic [2:0] FT_TAIL     = 3'b100;
  localparam logic [2:0] FT_HEADTAIL = 3'b101;
  localparam logic [2:0] FT_IDLE     = 3'b011;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // A flit that may open a packet.
  function automatic logic is_head(input logic [2:0] t);
    return (t == FT_HEAD) || (t == FT_HEADTAIL);
  endfunction

  // A flit that closes a packet.
  function automatic logic is_tail(input logic [2:0] t);
    return (t == FT_TAIL) || (t == FT_HEADTAIL);
  endfunction

  // Next port index, wrapping NPORT-1 back to 0.
  function automatic logic [2:0] port_inc(input logic [2:0] p);
    return (p >= 3'(NPORT - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // Index of the set bit of a one-hot port vector (0 when empty).
  function automatic logic [2:0] onehot_to_idx(input logic [NPORT-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NPORT; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick6.sv
// rtl/rr_pick6.sv - combinational six-way round-robin picker
module rr_pick6
  import router_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [2:0]       ptr,
  output logic [NPORT-1:0] grant,
  output logic             valid
);

  logic [2:0] cur;
  logic       found;

  // Scan requests starting at ptr and grant the first one found.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cur   = (ptr >= 3'(NPORT)) ? 3'd0 : ptr;
    for (int k = 0; k < NPORT; k++) begin
      if (!found && req[cur]) begin
        grant[cur] = 1'b1;
        found      = 1'b1;
      end
      cur = port_inc(cur);
    end
  end

  assign valid = found;

endmodule

// File: rtl/switch_arbiter_6port.sv
// rtl/switch_arbiter_6port.sv - wormhole round-robin output-port arbiter (optional SWARB_CREDIT_EN)
module switch_arbiter_6port
  import router_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORT-1:0]     req,
  input  logic [3*NPORT-1:0]   flit_type,
  input  logic                 out_ready,
  input  logic                 credit_in,
  output logic [NPORT-1:0]     sel,
  output logic [NPORT-1:0]     pop,
  output logic                 busy,
  output logic                 proto_err
`ifdef SWARB_CREDIT_EN
  ,
  output logic [CW-1:0]        credits
`endif
);

  arb_state_t       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       owner_q, owner_d;
  // Set from lock until the opening head flit has moved.
  logic             first_q, first_d;
  // Tracks a lone non-head request sitting at an idle port.
  logic [NPORT-1:0] stray_req_q, stray_req_d;
  logic [1:0]       stray_cnt_q, stray_cnt_d;

  logic [2:0]       ftype [NPORT];
  logic [NPORT-1:0] cand;
  logic [NPORT-1:0] pick_grant;
  logic             pick_valid;
  logic [NPORT-1:0] owner_oh;
  logic [2:0]       owner_type;
  logic             can_send;
  logic             xfer;
  logic             stray_now;
  logic             head_err;
  logic             stray_err;
  logic             credit_err;

  // Split the packed type bus and find the arbitration candidates.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      ftype[i] = flit_type[3*i +: 3];
      cand[i]  = req[i] & is_head(flit_type[3*i +: 3]);
    end
  end

  rr_pick6 u_pick (
    .req   (cand),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign owner_oh   = {{(NPORT-1){1'b0}}, 1'b1} << owner_q;
  assign owner_type = ftype[owner_q];
  assign xfer       = !reset && (state_q == LOCKED) && req[owner_q] && can_send;
  assign stray_now  = (state_q == IDLE) && $onehot(req) && !(|cand);

`ifdef SWARB_CREDIT_EN
  logic [CW-1:0] credits_q;
  logic          unused_ready;

  assign unused_ready = out_ready;
  assign can_send     = (credits_q != '0);
  assign credit_err   = credit_in && !xfer && (credits_q == CW'(CREDITS));
  assign credits      = credits_q;

  // Downstream slot count: spend on transfer, refill on credit_in, saturate at CREDITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= CW'(CREDITS);
    end else if (xfer && !credit_in) begin
      credits_q <= credits_q - CW'(1);
    end else if (credit_in && !xfer && (credits_q != CW'(CREDITS))) begin
      credits_q <= credits_q + CW'(1);
    end
  end
`else
  logic          unused_credit;
  logic [CW-1:0] unused_credit_cfg;

  assign unused_credit     = credit_in;
  assign unused_credit_cfg = CW'(CREDITS);
  assign can_send          = out_ready;
  assign credit_err        = 1'b0;
`endif

  // Next-state and output decode for the IDLE/LOCKED arbiter.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    first_d     = first_q;
    stray_req_d = '0;
    stray_cnt_d = 2'd0;
    sel         = '0;
    pop         = '0;
    busy        = (state_q == LOCKED);
    head_err    = 1'b0;
    stray_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid && can_send) begin
          owner_d = onehot_to_idx(pick_grant);
          first_d = 1'b1;
          state_d = LOCKED;
        end
        if (stray_now) begin
          stray_req_d = req;
          if (req == stray_req_q) begin
            stray_cnt_d = (stray_cnt_q == 2'd2) ? 2'd2 : stray_cnt_q + 2'd1;
            stray_err   = (stray_cnt_q == 2'd1);
          end else begin
            stray_cnt_d = 2'd1;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          sel      = owner_oh;
          pop      = owner_oh;
          first_d  = 1'b0;
          head_err = !first_q && (owner_type == FT_HEAD);
          if (is_tail(owner_type)) begin
            state_d = IDLE;
            ptr_d   = port_inc(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      sel  = '0;
      pop  = '0;
      busy = 1'b0;
    end
  end

  assign proto_err = !reset && (head_err || stray_err || credit_err);

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      owner_q     <= 3'd0;
      first_q     <= 1'b0;
      stray_req_q <= '0;
      stray_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      first_q     <= first_d;
      stray_req_q <= stray_req_d;
      stray_cnt_q <= stray_cnt_d;
    end
  end

endmodule

// File: tb/tb_switch_arbiter_6port.sv
// tb/tb_switch_arbiter_6port.sv - vector-table bench for switch_arbiter_6port
module tb_switch_arbiter_6port;
  import router_pkg::*;

  typedef struct {
    logic        rst;
    logic [5:0]  req;
    logic [17:0] ft;
    logic        rdy;
    logic        cin;
    logic [5:0]  sel;
    logic        busy;
    logic        err;
    logic [2:0]  cr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [5:0]  req;
  logic [17:0] flit_type;
  logic        out_ready;
  logic        credit_in;
  logic [5:0]  sel;
  logic [5:0]  pop;
  logic        busy;
  logic        proto_err;
`ifdef SWARB_CREDIT_EN
  logic [2:0]  credits;
`endif

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_tests;
  int   n_fail;

  switch_arbiter_6port #(.CREDITS(4), .CW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .flit_type (flit_type),
    .out_ready (out_ready),
    .credit_in (credit_in),
    .sel       (sel),
    .pop       (pop),
    .busy      (busy),
    .proto_err (proto_err)
`ifdef SWARB_CREDIT_EN
    ,
    .credits   (credits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  function automatic logic [17:0] ftp(input int p, input logic [2:0] t);
    logic [17:0] v;
    v = '0;
    v[3*p +: 3] = t;
    return v;
  endfunction

  task automatic add(input logic rst, input logic [5:0] r, input logic [17:0] f,
                     input logic rdy, input logic cin, input logic [5:0] s,
                     input logic b, input logic e, input logic [2:0] c);
    vec_t v;
    v.rst = rst; v.req = r; v.ft = f; v.rdy = rdy; v.cin = cin;
    v.sel = s; v.busy = b; v.err = e; v.cr = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, name, got, want);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b1;
    req = '0;
    flit_type = '0;
    out_ready = 1'b0;
    credit_in = 1'b0;

`ifndef SWARB_CREDIT_EN
    // single HEADTAIL on input 2, then ptr=3 picks 4 over 0, then ptr=5 wraps
    add(1, 6'b000000, '0, 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000100, ftp(2, FT_HEADTAIL), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000100, ftp(2, FT_HEADTAIL), 1, 0, 6'b000100, 1, 0, 0);
    add(0, 6'b000000, '0, 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b010001, ftp(0, FT_HEADTAIL) | ftp(4, FT_HEADTAIL), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b010001, ftp(0, FT_HEADTAIL) | ftp(4, FT_HEADTAIL), 1, 0, 6'b010000, 1, 0, 0);
    add(0, 6'b100001, ftp(0, FT_HEADTAIL) | ftp(5, FT_HEADTAIL), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b100001, ftp(0, FT_HEADTAIL) | ftp(5, FT_HEADTAIL), 1, 0, 6'b100000, 1, 0, 0);
    add(0, 6'b000001, ftp(0, FT_HEADTAIL), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000001, ftp(0, FT_HEADTAIL), 1, 0, 6'b000001, 1, 0, 0);
    // inputs 0 and 3 send 3-flit packets together from ptr=0: no interleaving
    add(1, 6'b000000, '0, 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b001001, ftp(0, FT_HEAD) | ftp(3, FT_HEAD), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b001001, ftp(0, FT_HEAD) | ftp(3, FT_HEAD), 1, 0, 6'b000001, 1, 0, 0);
    add(0, 6'b001001, ftp(0, FT_BODY) | ftp(3, FT_HEAD), 1, 0, 6'b000001, 1, 0, 0);
    add(0, 6'b001001, ftp(0, FT_TAIL) | ftp(3, FT_HEAD), 1, 0, 6'b000001, 1, 0, 0);
    add(0, 6'b001000, ftp(3, FT_HEAD), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b001000, ftp(3, FT_HEAD), 1, 0, 6'b001000, 1, 0, 0);
    add(0, 6'b001000, ftp(3, FT_BODY), 1, 0, 6'b001000, 1, 0, 0);
    add(0, 6'b001000, ftp(3, FT_TAIL), 1, 0, 6'b001000, 1, 0, 0);
    add(0, 6'b000000, '0, 1, 0, 6'b000000, 0, 0, 0);
    // no grant without out_ready, bubbles hold the lock, stray HEAD errors
    add(0, 6'b000010, ftp(1, FT_HEAD), 0, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000010, ftp(1, FT_HEAD), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000010, ftp(1, FT_HEAD), 1, 0, 6'b000010, 1, 0, 0);
    add(0, 6'b000000, '0, 1, 0, 6'b000000, 1, 0, 0);
    add(0, 6'b000010, ftp(1, FT_BODY), 0, 0, 6'b000000, 1, 0, 0);
    add(0, 6'b000010, ftp(1, FT_HEAD), 1, 0, 6'b000010, 1, 1, 0);
    add(0, 6'b000010, ftp(1, FT_BODY), 1, 0, 6'b000010, 1, 0, 0);
    // reset mid-packet, then a fresh head on input 2
    add(1, 6'b000010, ftp(1, FT_BODY), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000110, ftp(1, FT_BODY) | ftp(2, FT_HEAD), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000100, ftp(2, FT_HEAD), 1, 0, 6'b000100, 1, 0, 0);
    add(0, 6'b000100, ftp(2, FT_TAIL), 1, 0, 6'b000100, 1, 0, 0);
    // lone BODY at an idle port errors once on its second cycle
    add(0, 6'b010000, ftp(4, FT_BODY), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b010000, ftp(4, FT_BODY), 1, 0, 6'b000000, 0, 1, 0);
    add(0, 6'b010000, ftp(4, FT_BODY), 1, 0, 6'b000000, 0, 0, 0);
    add(0, 6'b000000, '0, 1, 0, 6'b000000, 0, 0, 0);
`else
    // 6-flit packet against 4 credits; out_ready held low to show it is ignored
    add(1, 6'b000000, '0, 0, 0, 6'b000000, 0, 0, 3'd4);
    add(0, 6'b000001, ftp(0, FT_HEAD), 0, 0, 6'b000000, 0, 0, 3'd4);
    add(0, 6'b000001, ftp(0, FT_HEAD), 0, 0, 6'b000001, 1, 0, 3'd4);
    add(0, 6'b000001, ftp(0, FT_BODY), 0, 0, 6'b000001, 1, 0, 3'd3);
    add(0, 6'b000001, ftp(0, FT_BODY), 0, 0, 6'b000001, 1, 0, 3'd2);
    add(0, 6'b000001, ftp(0, FT_BODY), 0, 0, 6'b000001, 1, 0, 3'd1);
    add(0, 6'b000001, ftp(0, FT_BODY), 0, 0, 6'b000000, 1, 0, 3'd0);
    add(0, 6'b000001, ftp(0, FT_BODY), 0, 1, 6'b000000, 1, 0, 3'd0);
    add(0, 6'b000001, ftp(0, FT_BODY), 0, 1, 6'b000001, 1, 0, 3'd1);
    add(0, 6'b000001, ftp(0, FT_TAIL), 0, 0, 6'b000001, 1, 0, 3'd1);
    // refill to the top, then one credit too many
    add(0, 6'b000000, '0, 0, 1, 6'b000000, 0, 0, 3'd0);
    add(0, 6'b000000, '0, 0, 1, 6'b000000, 0, 0, 3'd1);
    add(0, 6'b000000, '0, 0, 1, 6'b000000, 0, 0, 3'd2);
    add(0, 6'b000000, '0, 0, 1, 6'b000000, 0, 0, 3'd3);
    add(0, 6'b000000, '0, 0, 1, 6'b000000, 0, 1, 3'd4);
    add(0, 6'b000000, '0, 0, 0, 6'b000000, 0, 0, 3'd4);
    // reset after HEAD and one BODY restores credits; input 2 then wins again
    add(0, 6'b000100, ftp(2, FT_HEAD), 0, 0, 6'b000000, 0, 0, 3'd4);
    add(0, 6'b000100, ftp(2, FT_HEAD), 0, 0, 6'b000100, 1, 0, 3'd4);
    add(0, 6'b000100, ftp(2, FT_BODY), 0, 0, 6'b000100, 1, 0, 3'd3);
    add(1, 6'b000100, ftp(2, FT_BODY), 0, 0, 6'b000000, 0, 0, 3'd2);
    add(0, 6'b000100, ftp(2, FT_HEAD), 0, 0, 6'b000000, 0, 0, 3'd4);
    add(0, 6'b000100, ftp(2, FT_HEAD), 0, 0, 6'b000100, 1, 0, 3'd4);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      @(negedge clk);
      reset = tbl[i].rst;
      req = tbl[i].req;
      flit_type = tbl[i].ft;
      out_ready = tbl[i].rdy;
      credit_in = tbl[i].cin;
      exp_q.push_back(tbl[i]);
      #2;
      e = exp_q.pop_front();
      chk("sel", i, 32'(sel), 32'(e.sel));
      chk("pop", i, 32'(pop), 32'(e.sel));
      chk("busy", i, 32'(busy), 32'(e.busy));
      chk("proto_err", i, 32'(proto_err), 32'(e.err));
`ifdef SWARB_CREDIT_EN
      chk("credits", i, 32'(credits), 32'(e.cr));
`endif
    end

    @(negedge clk);
    req = '0;
    credit_in = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
